// File: rtl/adc_resp_pkg.sv
// Shared types and constants for the ADC link responder.
// The ADC_RESP_NOISE_EN build option uses the LFSR helper below.
package adc_resp_pkg;

  localparam int CFG_BITS = 6;
  localparam int RES_BITS = 12;
  localparam int NUM_CH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CONV  = 2'd2
  } state_e;

  typedef struct packed {
    logic sd;
    logic os;
    logic s1;
    logic s0;
    logic uni;
    logic slp;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{sd: 1'b1, os: 1'b0, s1: 1'b0, s0: 1'b0, uni: 1'b1, slp: 1'b0};

  // The channel number is not the natural bit order of the config word.
  function automatic logic [2:0] cfg_channel(input cfg_t c);
    cfg_channel = {c.s1, c.s0, c.os};
  endfunction

  // Right-shifting Galois LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    if (v[0]) begin
      lfsr_next = (v >> 1) ^ 16'hB400;
    end else begin
      lfsr_next = v >> 1;
    end
  endfunction

endpackage

// File: rtl/adc_resp_if.sv
// 4-wire ADC serial link between controller (master) and ADC/responder (slave).
interface adc_resp_if;
  logic ADC_CS_N;
  logic ADC_SCLK;
  logic ADC_DIN;
  logic ADC_DOUT;

  modport master (output ADC_CS_N, output ADC_SCLK, output ADC_DIN, input ADC_DOUT);
  modport slave  (input ADC_CS_N, input ADC_SCLK, input ADC_DIN, output ADC_DOUT);
endinterface

// File: rtl/sync_edge.sv
// 2-FF synchronizer plus an edge register; rise/fall pulses are valid one cycle.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/adc_responder.sv
// Emulates the DE1-SoC 12-bit 8-channel ADC with deterministic per-channel ramps.
// Define ADC_RESP_NOISE_EN to add 3 bits of LFSR noise to each result.
module adc_responder
  import adc_resp_pkg::*;
#(
  parameter int          CONV_CYCLES = 80,
  parameter logic [11:0] STEP        = 12'd16
) (
  input  logic              clk,
  input  logic              reset_n,
  adc_resp_if.slave         adc,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CFG_BITS-1:0] last_cfg
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic din_s, din_rise_s, din_fall_s;
  logic sync_unused_s;

  // CS_N idles high so it must reset high to avoid a phantom frame start.
  sync_edge #(.RST_VAL(1'b1)) u_cs   (.clk(clk), .reset_n(reset_n), .d_i(adc.ADC_CS_N),
                                      .level_o(cs_lvl_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s));
  sync_edge #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .reset_n(reset_n), .d_i(adc.ADC_SCLK),
                                      .level_o(sclk_lvl_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s));
  sync_edge #(.RST_VAL(1'b0)) u_din  (.clk(clk), .reset_n(reset_n), .d_i(adc.ADC_DIN),
                                      .level_o(din_s), .rise_o(din_rise_s), .fall_o(din_fall_s));

  assign sync_unused_s = ^{cs_lvl_s, sclk_lvl_s, din_rise_s, din_fall_s};

  state_e              state_q, state_d;
  logic [CFG_BITS-1:0] cfg_sr_q, cfg_sr_d;
  logic [3:0]          rise_cnt_q, rise_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                dout_q, dout_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  cfg_t                last_cfg_q, last_cfg_d;
  logic [RES_BITS-1:0] result_q, result_d;
  logic [RES_BITS-1:0] ramp_q [NUM_CH];
  logic [RES_BITS-1:0] ramp_d [NUM_CH];
  logic [CNT_W-1:0]    conv_cnt_q, conv_cnt_d;
`ifdef ADC_RESP_NOISE_EN
  logic [15:0]         lfsr_q, lfsr_d;
`endif

  logic [2:0]          ch_s;
  logic [RES_BITS-1:0] ramp_sel_s, ramp_inc_s, raw_s, raw_noisy_s, result_new_s;
  logic                conv_last_s;

  assign conv_last_s = (conv_cnt_q == CNT_W'(CONV_CYCLES - 1));
  assign ch_s        = cfg_channel(last_cfg_q);
  assign ramp_sel_s  = ramp_q[ch_s];
  assign ramp_inc_s  = ({9'd0, ch_s} + 12'd1) * STEP;
  assign raw_s       = last_cfg_q.sd ? ramp_sel_s : 12'h800;
`ifdef ADC_RESP_NOISE_EN
  assign raw_noisy_s = raw_s + {9'd0, lfsr_q[2:0]};
`else
  assign raw_noisy_s = raw_s;
`endif
  assign result_new_s = last_cfg_q.uni ? raw_noisy_s : (raw_noisy_s ^ 12'h800);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a CS_N edge always wins over a coincident SCLK edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cs_fall_s) state_d = SHIFT;
        else           state_d = IDLE;
      end
      SHIFT: begin
        if (cs_rise_s) state_d = (rise_cnt_q >= 4'd6) ? CONV : IDLE;
        else           state_d = SHIFT;
      end
      CONV: begin
        if (cs_fall_s)        state_d = SHIFT;
        else if (conv_last_s) state_d = IDLE;
        else                  state_d = CONV;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: shifting, result bits, conversion and ramp update.
  always_comb begin
    cfg_sr_d   = cfg_sr_q;
    rise_cnt_d = rise_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    last_cfg_d = last_cfg_q;
    result_d   = result_q;
    ramp_d     = ramp_q;
    conv_cnt_d = conv_cnt_q;
`ifdef ADC_RESP_NOISE_EN
    lfsr_d     = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall_s) begin
          dout_d     = result_q[RES_BITS-1];
          bit_cnt_d  = 4'd0;
          rise_cnt_d = 4'd0;
          cfg_sr_d   = '0;
        end else begin
          dout_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          dout_d     = 1'b0;
          conv_cnt_d = '0;
          if (rise_cnt_q >= 4'd6) begin
            last_cfg_d = cfg_t'(cfg_sr_q);
            done_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise_s) begin
          if (rise_cnt_q < 4'd6) cfg_sr_d = {cfg_sr_q[CFG_BITS-2:0], din_s};
          else                   cfg_sr_d = cfg_sr_q;
          if (rise_cnt_q != 4'd15) rise_cnt_d = rise_cnt_q + 4'd1;
          else                     rise_cnt_d = rise_cnt_q;
        end else if (sclk_fall_s) begin
          // bit_cnt_q counts falls already seen; bit 11 went out at CS_N fall.
          if (bit_cnt_q < 4'd11) begin
            dout_d    = result_q[4'd10 - bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            dout_d = 1'b0;
          end
        end else begin
          dout_d = dout_q;
        end
      end
      CONV: begin
        if (cs_fall_s) begin
          err_d      = 1'b1;
          dout_d     = result_q[RES_BITS-1];
          bit_cnt_d  = 4'd0;
          rise_cnt_d = 4'd0;
          cfg_sr_d   = '0;
        end else if (conv_last_s) begin
          dout_d   = 1'b0;
          result_d = result_new_s;
          if (last_cfg_q.sd) ramp_d[ch_s] = ramp_sel_s + ramp_inc_s;
          else               ramp_d[ch_s] = ramp_sel_s;
`ifdef ADC_RESP_NOISE_EN
          lfsr_d = lfsr_next(lfsr_q);
`endif
        end else begin
          dout_d     = 1'b0;
          conv_cnt_d = conv_cnt_q + CNT_W'(1);
        end
      end
      default: dout_d = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_sr_q   <= '0;
      rise_cnt_q <= 4'd0;
      bit_cnt_q  <= 4'd0;
      dout_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_cfg_q <= CFG_DEFAULT;
      result_q   <= '0;
      conv_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ramp_q[i] <= '0;
      end
`ifdef ADC_RESP_NOISE_EN
      lfsr_q     <= 16'hACE1;
`endif
    end else begin
      cfg_sr_q   <= cfg_sr_d;
      rise_cnt_q <= rise_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      err_q      <= err_d;
      last_cfg_q <= last_cfg_d;
      result_q   <= result_d;
      conv_cnt_q <= conv_cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        ramp_q[i] <= ramp_d[i];
      end
`ifdef ADC_RESP_NOISE_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign adc.ADC_DOUT = dout_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;
  assign last_cfg     = last_cfg_q;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: frames push expected words/pulses, monitors pop.
module tb_adc_responder;

  localparam int CONV = 80;
  localparam int POST = CONV + 12;

  logic       clk;
  logic       reset_n;
  logic       frame_done;
  logic       frame_err;
  logic [5:0] last_cfg;

  adc_resp_if bus ();

  adc_responder #(.CONV_CYCLES(CONV), .STEP(12'd16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adc        (bus),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .last_cfg   (last_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] exp_q [$];
  logic [1:0]  ev_q  [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [1:0] EV_DONE = 2'b01;
  localparam logic [1:0] EV_ERR  = 2'b10;

  logic [5:0]  cfg_tab [9] = '{6'b100000, 6'b110010, 6'b100010, 6'b000010, 6'b000000,
                               6'b110010, 6'b100010, 6'b111110, 6'b111110};
  logic [11:0] exp_tab [9] = '{12'h000, 12'h800, 12'h000, 12'h010, 12'h800,
                               12'h000, 12'h020, 12'h020, 12'h000};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %03h required %03h", nm, got, want);
    end
  endtask

  task automatic run_frame(input logic [5:0] cfg, input int n_sclk, input logic [11:0] want,
                           input int post_wait, input bit pre_err);
    if (pre_err) ev_q.push_back(EV_ERR);
    if (n_sclk >= 12) exp_q.push_back(want);
    ev_q.push_back((n_sclk >= 6) ? EV_DONE : EV_ERR);
    bus.ADC_CS_N = 1'b0;
    tick(6);
    for (int i = 0; i < n_sclk; i++) begin
      bus.ADC_DIN = (i < 6) ? cfg[5-i] : 1'b0;
      tick(4);
      bus.ADC_SCLK = 1'b1;
      tick(4);
      bus.ADC_SCLK = 1'b0;
    end
    bus.ADC_DIN = 1'b0;
    tick(6);
    bus.ADC_CS_N = 1'b1;
    tick(post_wait);
  endtask

  // Monitor: collects DOUT at each SCLK rise like the controller, checks pulses.
  initial begin
    logic [11:0] sh;
    logic [11:0] e;
    logic [1:0]  ev;
    int          nb;
    int          fr;
    logic        cs_p;
    logic        sclk_p;
    sh = '0; nb = 0; fr = 0; cs_p = 1'b1; sclk_p = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_done || frame_err) begin
        n_tests++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL pulse_unexpected: got done=%0b err=%0b required none", frame_done, frame_err);
        end else begin
          ev = ev_q.pop_front();
          if ({frame_err, frame_done} !== ev) begin
            n_fail++;
            $display("FAIL pulse_kind: got err,done=%02b required %02b", {frame_err, frame_done}, ev);
          end
        end
      end
      if (!reset_n) begin
        nb = 0;
      end else begin
        if (!bus.ADC_CS_N && !sclk_p && bus.ADC_SCLK) begin
          sh = {sh[10:0], bus.ADC_DOUT};
          nb++;
        end
        if (!cs_p && bus.ADC_CS_N && nb >= 12) begin
          fr++;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL dout_unexpected frame %0d: got %03h required no frame", fr, sh);
          end else begin
            e = exp_q.pop_front();
            if (sh !== e) begin
              n_fail++;
              $display("FAIL dout_word frame %0d: got %03h required %03h", fr, sh, e);
            end
          end
        end
        if (cs_p && !bus.ADC_CS_N) nb = 0;
      end
      cs_p   = bus.ADC_CS_N;
      sclk_p = bus.ADC_SCLK;
    end
  end

  // Stimulus.
  initial begin
    bus.ADC_CS_N = 1'b1;
    bus.ADC_SCLK = 1'b0;
    bus.ADC_DIN  = 1'b0;
    reset_n      = 1'b0;
    tick(3);
    chk("reset_dout", {11'd0, bus.ADC_DOUT}, 12'h000);
    chk("reset_done", {11'd0, frame_done}, 12'h000);
    chk("reset_err", {11'd0, frame_err}, 12'h000);
    chk("reset_last_cfg", {6'd0, last_cfg}, {6'd0, 6'b100010});
    reset_n = 1'b1;
    tick(5);

    // Pipelined reads, bipolar, differential and channel 7.
    for (int i = 0; i < 9; i++) begin
      run_frame(cfg_tab[i], 12, exp_tab[i], POST, 1'b0);
    end
    chk("last_cfg_ch7", {6'd0, last_cfg}, {6'd0, 6'b111110});

    // Short frame: 4 SCLKs only.
    run_frame(6'b010101, 4, 12'h000, POST, 1'b0);
    chk("last_cfg_after_short", {6'd0, last_cfg}, {6'd0, 6'b111110});

    run_frame(6'b100010, 12, 12'h080, POST, 1'b0);
    run_frame(6'b100010, 12, 12'h030, POST, 1'b0);
    // Abort: next frame starts ~20 cycles into the conversion.
    run_frame(6'b100010, 12, 12'h040, 23, 1'b0);
    run_frame(6'b100010, 12, 12'h040, POST, 1'b1);
    run_frame(6'b111110, 12, 12'h050, POST, 1'b0);

    // Reset in the middle of a frame; result is 0x100 so bit 8 is on DOUT.
    bus.ADC_CS_N = 1'b0;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      bus.ADC_DIN = 1'b1;
      tick(4);
      bus.ADC_SCLK = 1'b1;
      tick(4);
      bus.ADC_SCLK = 1'b0;
    end
    tick(5);
    chk("dout_before_reset", {11'd0, bus.ADC_DOUT}, 12'h001);
    reset_n = 1'b0;
    tick(2);
    chk("dout_in_reset", {11'd0, bus.ADC_DOUT}, 12'h000);
    chk("last_cfg_in_reset", {6'd0, last_cfg}, {6'd0, 6'b100010});
    bus.ADC_CS_N = 1'b1;
    bus.ADC_DIN  = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(5);

    // Ramp wrap on ch0: frame k reads conversion k-1 = 16*(k-2), frame 1 reads reset value.
    for (int k = 1; k <= 258; k++) begin
      logic [11:0] w;
      w = (k == 1) ? 12'h000 : 12'((k - 2) * 16);
      run_frame(6'b100010, 12, w, POST, 1'b0);
    end

    tick(20);
    chk("dout_queue_drained", 12'(exp_q.size()), 12'h000);
    chk("pulse_queue_drained", 12'(ev_q.size()), 12'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
